// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode/state encodings and helpers shared by the universal shift register
package shift_reg_pkg;
  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    ROR  = 3'b011,
    ROL  = 3'b100,
    ASR  = 3'b101,
    LOAD = 3'b110,
    CLR  = 3'b111
  } mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_shift_mode(input mode_t m);
    return m inside {SHR, SHL, ROR, ROL, ASR};
  endfunction
endpackage

// File: rtl/shift_reg_burst_ctrl.sv
// shift_reg_burst_ctrl: burst FSM and shift counter selecting the mode the datapath applies
module shift_reg_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  start,
  input  mode_t mode,
  output mode_t eff_mode,
  output logic  shift_en,
  output logic  busy,
  output logic  done
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  state_t state;
  mode_t bmode;
  logic [CNT_W-1:0] count;
  logic accept, last;
  // the accepting edge is shift 1, so RUN performs BURST_LEN-1 further shifts
  assign accept = state == IDLE && en && start && is_shift_mode(mode);
  assign last = int'(count) + 2 >= BURST_LEN;
  always_comb begin
    eff_mode = state == RUN ? bmode : mode;
    shift_en = en && state != DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bmode <= HOLD;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bmode <= mode;
          count <= '0;
          state <= BURST_LEN == 1 ? DONE : RUN;
          busy  <= BURST_LEN != 1;
          done  <= BURST_LEN == 1;
        end
        RUN: if (en) begin
          count <= count + CNT_W'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register with autonomous burst shifting
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);
  mode_t eff_mode;
  logic shift_en;
  logic [WIDTH-1:0] nxt;
  shift_reg_burst_ctrl #(.BURST_LEN(BURST_LEN)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .mode     (mode_t'(mode)),
    .eff_mode (eff_mode),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );
  always_comb begin
    nxt = q;
    case (eff_mode)
      SHR:     nxt = {sin_r, q[WIDTH-1:1]};
      SHL:     nxt = {q[WIDTH-2:0], sin_l};
      ROR:     nxt = {q[0], q[WIDTH-1:1]};
      ROL:     nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      ASR:     nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      LOAD:    nxt = pin;
      CLR:     nxt = '0;
      default: nxt = q;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (shift_en) q <= nxt;
  end
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed vectors with hand-computed expectations for shift_reg_univ
module tb_shift_reg_univ;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sin_r = 1'b0, sin_l = 1'b0, start = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] pin = 4'h0, q;
  logic sout_r, sout_l, busy, done;
  int checks = 0, errors = 0;
  shift_reg_univ #(.WIDTH(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .start(start), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic stat(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
    chk({tag, "_q"}, {4'b0, q}, {4'b0, eq});
    chk({tag, "_busy"}, {7'b0, busy}, {7'b0, eb});
    chk({tag, "_done"}, {7'b0, done}, {7'b0, ed});
  endtask
  initial begin
    #12;
    stat("reset", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    // direct ops
    mode = 3'b110; pin = 4'b1001; step(); chk("load", {4'b0, q}, 8'b1001);
    mode = 3'b001; sin_r = 1'b1; step(); chk("shr1", {4'b0, q}, 8'b1100);
    step(); chk("shr2", {4'b0, q}, 8'b1110);
    mode = 3'b010; sin_l = 1'b0; step(); chk("shl", {4'b0, q}, 8'b1100);
    chk("sout_r", {7'b0, sout_r}, 8'd0);
    chk("sout_l", {7'b0, sout_l}, 8'd1);
    mode = 3'b110; pin = 4'b1001; step();
    mode = 3'b011; step(); chk("ror", {4'b0, q}, 8'b1100);
    mode = 3'b100; step(); chk("rol", {4'b0, q}, 8'b1001);
    mode = 3'b110; pin = 4'b1000; step();
    mode = 3'b101; step(); chk("asr1", {4'b0, q}, 8'b1100);
    step(); chk("asr2", {4'b0, q}, 8'b1110);
    mode = 3'b000; step(); chk("hold", {4'b0, q}, 8'b1110);
    en = 1'b0; mode = 3'b111; step(); chk("en_off", {4'b0, q}, 8'b1110);
    en = 1'b1; step(); chk("clr", {4'b0, q}, 8'b0000);
    // burst SHR with live serial stream, mode changed mid-run
    mode = 3'b001; start = 1'b1; sin_r = 1'b1; step(); stat("b1", 4'b1000, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b010; sin_r = 1'b0; step(); stat("b2", 4'b0100, 1'b1, 1'b0);
    sin_r = 1'b1; step(); stat("b3", 4'b1010, 1'b1, 1'b0);
    step(); stat("b4", 4'b1101, 1'b0, 1'b1);
    mode = 3'b000; step(); stat("b_after", 4'b1101, 1'b0, 1'b0);
    // burst ROR with a two-cycle enable stall
    mode = 3'b110; pin = 4'b0001; step();
    mode = 3'b011; start = 1'b1; step(); stat("s1", 4'b1000, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; en = 1'b0; step(); stat("s_stall1", 4'b1000, 1'b1, 1'b0);
    step(); stat("s_stall2", 4'b1000, 1'b1, 1'b0);
    en = 1'b1; step(); stat("s2", 4'b0100, 1'b1, 1'b0);
    step(); stat("s3", 4'b0010, 1'b1, 1'b0);
    start = 1'b1; mode = 3'b001; step(); stat("s4", 4'b0001, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000; step(); stat("s_after", 4'b0001, 1'b0, 1'b0);
    // start with LOAD is a one-shot direct op
    mode = 3'b110; pin = 4'b0110; start = 1'b1; step(); stat("ld_start", 4'b0110, 1'b0, 1'b0);
    step(); stat("ld_start2", 4'b0110, 1'b0, 1'b0);
    start = 1'b0;
    // async reset mid-burst
    mode = 3'b110; pin = 4'b0101; step();
    mode = 3'b010; sin_l = 1'b1; start = 1'b1; step(); stat("pre_rst", 4'b1011, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; en = 1'b0;
    #2 rst = 1'b1;
    #1 stat("async_rst", 4'b0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    en = 1'b1;
    step(); stat("post_rst1", 4'b0000, 1'b0, 1'b0);
    step(); stat("post_rst2", 4'b0000, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
